// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, round constants, GF(2^8) doubling,
// block-level state encoding and the fixed round count.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8 * int'(b) -: 8];
  endfunction

  // Round constant for round 1..10; any other index yields zero.
  function automatic logic [7:0] rcon_of(input logic [4:0] idx);
    case (idx)
      5'd1:    return 8'h01;
      5'd2:    return 8'h02;
      5'd3:    return 8'h04;
      5'd4:    return 8'h08;
      5'd5:    return 8'h10;
      5'd6:    return 8'h20;
      5'd7:    return 8'h40;
      5'd8:    return 8'h80;
      5'd9:    return 8'h1b;
      5'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 encryption round together with the matching
// key-schedule step. Byte i of a 128-bit word is bits [127-8i -: 8];
// state byte index is 4*column + row.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  input  logic         last,
  output logic [127:0] st_out,
  output logic [127:0] rk_out
);

  logic [7:0]   s_sub [16];
  logic [7:0]   s_shf [16];
  logic [7:0]   s_mix [16];
  logic [127:0] mixed;
  logic [31:0]  w0, w1, w2, w3, tmp;
  logic [31:0]  n0, n1, n2, n3;

  // SubBytes on every state byte.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      s_sub[i] = sbox(st_in[127 - 8*i -: 8]);
    end
  end

  // ShiftRows: row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s_shf[4*c + r] = s_sub[4*((c + r) % 4) + r];
      end
    end
  end

  // MixColumns on each column.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      s_mix[4*c]     = xtime(s_shf[4*c]) ^ xtime(s_shf[4*c+1]) ^ s_shf[4*c+1]
                     ^ s_shf[4*c+2] ^ s_shf[4*c+3];
      s_mix[4*c + 1] = s_shf[4*c] ^ xtime(s_shf[4*c+1]) ^ xtime(s_shf[4*c+2])
                     ^ s_shf[4*c+2] ^ s_shf[4*c+3];
      s_mix[4*c + 2] = s_shf[4*c] ^ s_shf[4*c+1] ^ xtime(s_shf[4*c+2])
                     ^ xtime(s_shf[4*c+3]) ^ s_shf[4*c+3];
      s_mix[4*c + 3] = xtime(s_shf[4*c]) ^ s_shf[4*c] ^ s_shf[4*c+1]
                     ^ s_shf[4*c+2] ^ xtime(s_shf[4*c+3]);
    end
  end

  // Final round skips MixColumns; repack to a flat word.
  always_comb begin
    mixed = '0;
    for (int i = 0; i < 16; i++) begin
      mixed[127 - 8*i -: 8] = last ? s_shf[i] : s_mix[i];
    end
  end

  // Key schedule: RotWord, SubWord and rcon on the last word, then chain XORs.
  always_comb begin
    w0  = rk_in[127:96];
    w1  = rk_in[95:64];
    w2  = rk_in[63:32];
    w3  = rk_in[31:0];
    tmp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0  = w0 ^ tmp;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
  end

  assign rk_out = {n0, n1, n2, n3};
  assign st_out = mixed ^ rk_out;

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core. Applies ROUNDS_PER_CYCLE chained rounds
// per clock with on-the-fly key expansion; valid/ready on both sides.
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  // Counter value at the start of the cycle whose rounds end with round 10.
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - ROUNDS_PER_CYCLE + 1);

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;

  logic [127:0] st_c [ROUNDS_PER_CYCLE+1];
  logic [127:0] rk_c [ROUNDS_PER_CYCLE+1];

  assign st_c[0] = st_q;
  assign rk_c[0] = rk_q;

  // Chain of round units; unit k performs round rnd_q + k.
  for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_round
    logic [4:0] ridx;
    assign ridx = {1'b0, rnd_q} + 5'(k);

    aes_round_unit u_round (
      .st_in  (st_c[k]),
      .rk_in  (rk_c[k]),
      .rcon   (rcon_of(ridx)),
      .last   (ridx == 5'(NUM_ROUNDS)),
      .st_out (st_c[k+1]),
      .rk_out (rk_c[k+1])
    );
  end

  // State, counter, datapath and output registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
    end
  end

  // Next-state, datapath selection and handshake outputs.
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    st_d      = st_q;
    rk_d      = rk_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_data ^ in_key;
          rk_d    = in_key;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        st_d = st_c[ROUNDS_PER_CYCLE];
        rk_d = rk_c[ROUNDS_PER_CYCLE];
        if (rnd_q == LAST_RND) begin
          // Counter parks at 10 once the final round is done.
          rnd_d   = 4'(NUM_ROUNDS);
          out_d   = st_c[ROUNDS_PER_CYCLE];
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + 4'(ROUNDS_PER_CYCLE);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: four instances (1, 2, 5, 10 rounds per cycle)
// with independent stimulus, a per-instance expected-ciphertext queue and a
// negedge monitor that pops on every output handshake.
module tb_aes128_iter_core;

  localparam int RPC_T [4] = '{1, 2, 5, 10};
  localparam int N_T   [4] = '{10, 5, 2, 1};

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst       [4];
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [127:0] in_data   [4];
  logic [127:0] in_key    [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] out_data  [4];
  logic         busy      [4];

  logic [127:0] sbq [4][$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_iter_core #(.ROUNDS_PER_CYCLE(RPC_T[g])) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_key    (in_key[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );

    // Scoreboard: every output handshake must match the oldest expected block.
    always @(negedge clk) begin
      if (!rst[g] && out_valid[g] && out_ready[g]) begin
        if (sbq[g].size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_out dut%0d observed=%h expected=none", g, out_data[g]);
        end else begin
          check($sformatf("ct_dut%0d", g), out_data[g], sbq[g].pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Send one block to all four instances at once and measure output latency.
  task automatic drive_all(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] exp, input string name);
    int first_ov [4];
    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = pt;
      in_key[d]   = key;
      sbq[d].push_back(exp);
      first_ov[d] = -1;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = '0;
      in_key[d]   = '0;
      check($sformatf("%s_busy_dut%0d", name, d), 128'({busy[d], in_ready[d]}), 128'b10);
    end
    for (int t = 1; t <= 14; t++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++)
        if (out_valid[d] && first_ov[d] < 0) first_ov[d] = t;
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_latency_dut%0d", name, d), 128'(first_ov[d]), 128'(N_T[d]));
      check($sformatf("%s_drained_dut%0d", name, d), 128'(sbq[d].size()), 128'd0);
    end
  endtask

  initial begin
    int cap1 [4];
    int cap2 [4];
    int ncap [4];
    bit switched [4];
    int t;
    bit seen;

    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; in_key[d] = '0;
      out_ready[d] = 1'b1;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b0;
      check($sformatf("rst_ctl_dut%0d", d),
            128'({out_valid[d], busy[d], in_ready[d]}), 128'b001);
      check($sformatf("rst_data_dut%0d", d), out_data[d], 128'd0);
    end

    // Known-answer vectors on every unroll factor.
    drive_all(PT_B, KEY_B, CT_B, "appB");
    drive_all(PT_C, KEY_C, CT_C, "appC1");
    drive_all(128'd0, 128'd0, CT_Z, "zero");

    // Back-to-back with in_valid held high the whole time.
    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b1; in_data[d] = PT_B; in_key[d] = KEY_B;
      sbq[d].push_back(CT_B);
      ncap[d] = 0; switched[d] = 1'b0; cap1[d] = 0; cap2[d] = 0;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (in_valid[d] && in_ready[d]) begin
          ncap[d]++;
          if (ncap[d] == 1) cap1[d] = cyc; else cap2[d] = cyc;
        end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        if (ncap[d] == 1 && !switched[d]) begin
          in_data[d] = PT_C; in_key[d] = KEY_C;
          sbq[d].push_back(CT_C);
          switched[d] = 1'b1;
        end else if (ncap[d] >= 2) begin
          in_valid[d] = 1'b0;
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      check($sformatf("b2b_ncap_dut%0d", d), 128'(ncap[d]), 128'd2);
      check($sformatf("b2b_gap_dut%0d", d), 128'(cap2[d] - cap1[d]), 128'(N_T[d] + 2));
      check($sformatf("b2b_drained_dut%0d", d), 128'(sbq[d].size()), 128'd0);
    end

    // Backpressure on the one-round-per-cycle instance.
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = PT_B; in_key[0] = KEY_B;
    sbq[0].push_back(CT_B);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("bp_reached", 128'(out_valid[0]), 128'd1);
    for (int k = 0; k < 20; k++) begin
      check("bp_ctl", 128'({out_valid[0], in_ready[0], busy[0]}), 128'b101);
      check("bp_data", out_data[0], CT_B);
      if (k == 5) begin
        in_valid[0] = 1'b1; in_data[0] = PT_C; in_key[0] = KEY_C;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ctl", 128'({out_valid[0], in_ready[0], busy[0]}), 128'b010);
    check("bp_retain_data", out_data[0], CT_B);
    check("bp_drained", 128'(sbq[0].size()), 128'd0);
    @(posedge clk); #1;
    check("bp_pulse_ignored", 128'({in_ready[0], busy[0]}), 128'b10);

    // Reset asserted at the third RUN edge.
    in_valid[0] = 1'b1; in_data[0] = PT_B; in_key[0] = KEY_B;
    sbq[0].push_back(CT_B);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_busy", 128'(busy[0]), 128'd1);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    sbq[0].delete();
    check("midrun_rst_ctl", 128'({out_valid[0], busy[0], in_ready[0]}), 128'b001);
    check("midrun_rst_data", out_data[0], 128'd0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen = 1'b1;
    end
    check("midrun_no_stale", 128'(seen), 128'd0);
    in_valid[0] = 1'b1; in_data[0] = PT_C; in_key[0] = KEY_C;
    sbq[0].push_back(CT_C);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
    end
    check("midrun_next_drained", 128'(sbq[0].size()), 128'd0);

    // Reset in DONE with out_ready high in the same cycle.
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1; in_data[0] = '0; in_key[0] = '0;
    sbq[0].push_back(CT_Z);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rstdone_reached", 128'(out_valid[0]), 128'd1);
    check("rstdone_data_before", out_data[0], CT_Z);
    rst[0] = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    sbq[0].delete();
    check("rstdone_ctl", 128'({out_valid[0], busy[0], in_ready[0]}), 128'b001);
    check("rstdone_data", out_data[0], 128'd0);
    @(posedge clk); #1;

    for (int d = 0; d < 4; d++)
      check($sformatf("final_drained_dut%0d", d), 128'(sbq[d].size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
